// File: rtl/booth_entry_ctrl.sv
// Key-entry sequencer for the Booth multiplier: builds two signed decimal operands,
// strobes the datapath, waits for done. Optional watchdog: define BOOTH_CTRL_TIMEOUT_EN.
module booth_entry_ctrl #(
  parameter int WIDTH          = 8,
  parameter int MAX_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             mult_done,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             mult_start,
  output logic [WIDTH-1:0] entry_mag,
  output logic             entry_neg,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic             result_valid,
  output logic             error
);

  typedef enum logic [2:0] {
    S_A      = 3'd0,
    S_B      = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int EXT_W = WIDTH + 4;
  localparam logic [WIDTH-1:0] MAG_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [3:0]       KEY_ENTER = 4'hA;
  localparam logic [3:0]       KEY_NEG   = 4'hB;
  localparam logic [3:0]       KEY_CLEAR = 4'hC;

  if (WIDTH < 2 || MAX_DIGITS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("booth_entry_ctrl: invalid parameter value");
  end

  state_t           state;
  logic [CNT_W-1:0] digit_cnt;
  logic [EXT_W-1:0] mag_ext;
  logic [WIDTH-1:0] mag_sat;
  logic [WIDTH-1:0] entry_signed;
  logic             is_digit;

  // Accumulate in four extra bits so mag*10+9 cannot wrap before the clamp.
  assign is_digit     = (key_code <= 4'd9);
  assign mag_ext      = EXT_W'(entry_mag) * EXT_W'(10) + EXT_W'(key_code);
  assign mag_sat      = (mag_ext > EXT_W'(MAG_MAX)) ? MAG_MAX : mag_ext[WIDTH-1:0];
  assign entry_signed = entry_neg ? (~entry_mag + 1'b1) : entry_mag;
  assign state_o      = state;

`ifdef BOOTH_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            error_reg;
  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_A;
      digit_cnt    <= '0;
      entry_mag    <= '0;
      entry_neg    <= 1'b0;
      operand_a    <= '0;
      operand_b    <= '0;
      mult_start   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
`ifdef BOOTH_CTRL_TIMEOUT_EN
      wait_cnt     <= '0;
      error_reg    <= 1'b0;
`endif
    end else begin
      mult_start <= 1'b0;
      case (state)
        S_A, S_B: begin
          if (key_valid) begin
            if (is_digit) begin
              if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                entry_mag <= mag_sat;
                digit_cnt <= digit_cnt + 1'b1;
              end
            end else if (key_code == KEY_NEG) begin
              entry_neg <= ~entry_neg;
            end else if (key_code == KEY_CLEAR) begin
              entry_mag <= '0;
              entry_neg <= 1'b0;
              digit_cnt <= '0;
              operand_a <= '0;
              operand_b <= '0;
              state     <= S_A;
            end else if (key_code == KEY_ENTER) begin
              entry_mag <= '0;
              entry_neg <= 1'b0;
              digit_cnt <= '0;
              if (state == S_A) begin
                operand_a <= entry_signed;
                state     <= S_B;
              end else begin
                operand_b  <= entry_signed;
                state      <= S_RUN;
                mult_start <= 1'b1;
                busy       <= 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          state <= S_WAIT;
`ifdef BOOTH_CTRL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // Done takes priority over any key and over a same-cycle watchdog expiry.
          if (mult_done) begin
            state        <= S_RESULT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end
`ifdef BOOTH_CTRL_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_RESULT;
            busy      <= 1'b0;
            error_reg <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESULT: begin
          // The key that leaves the result screen is swallowed, not interpreted.
          if (key_valid) begin
            state        <= S_A;
            entry_mag    <= '0;
            entry_neg    <= 1'b0;
            digit_cnt    <= '0;
            result_valid <= 1'b0;
`ifdef BOOTH_CTRL_TIMEOUT_EN
            error_reg    <= 1'b0;
`endif
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_entry_ctrl.sv
// Directed self-checking bench for booth_entry_ctrl (WIDTH=8, MAX_DIGITS=3, TIMEOUT_CYCLES=16).
module tb_booth_entry_ctrl;

  localparam logic [3:0] K_ENTER = 4'hA;
  localparam logic [3:0] K_NEG   = 4'hB;
  localparam logic [3:0] K_CLR   = 4'hC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       mult_done = 1'b0;
  logic [7:0] operand_a, operand_b, entry_mag;
  logic       mult_start, entry_neg, busy, result_valid, error;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_entry_ctrl #(
    .WIDTH(8),
    .MAX_DIGITS(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .mult_done(mult_done),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .mult_start(mult_start),
    .entry_mag(entry_mag),
    .entry_neg(entry_neg),
    .state_o(state_o),
    .busy(busy),
    .result_valid(result_valid),
    .error(error)
  );

  // One key pulse spanning exactly one rising edge; returns on the following falling edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    $display("key %h -> state=%0d mag=%0d neg=%0b a=%h b=%h", k, state_o, entry_mag, entry_neg, operand_a, operand_b);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
    $display("mult_done -> state=%0d result_valid=%0b", state_o, result_valid);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({operand_a, operand_b, mult_start, entry_mag, entry_neg, busy, result_valid, error} !== 29'd0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", {operand_a, operand_b, mult_start, entry_mag, entry_neg, busy, result_valid, error}); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state act=%0d exp=0", state_o); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    int pulses;
    press(4'd1); press(4'd2);
    checks++; if (entry_mag !== 8'd12) begin errors++; $display("FAIL basic_mag act=%0d exp=12", entry_mag); end
    press(K_ENTER);
    checks++; if (operand_a !== 8'h0C) begin errors++; $display("FAIL basic_op_a act=%h exp=0c", operand_a); end
    checks++; if (state_o !== 3'd1 || entry_mag !== 8'd0) begin errors++; $display("FAIL basic_after_a act=st%0d/mag%0d exp=st1/mag0", state_o, entry_mag); end
    press(K_NEG);
    checks++; if (entry_neg !== 1'b1) begin errors++; $display("FAIL basic_neg act=%0b exp=1", entry_neg); end
    press(4'd5); press(K_ENTER);
    checks++; if (mult_start !== 1'b1 || state_o !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL basic_run act=start%0b/st%0d/busy%0b exp=1/2/1", mult_start, state_o, busy); end
    checks++; if (operand_b !== 8'hFB) begin errors++; $display("FAIL basic_op_b act=%h exp=fb", operand_b); end
    pulses = 1;
    @(negedge clk);
    checks++; if (state_o !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL basic_wait act=st%0d/busy%0b exp=3/1", state_o, busy); end
    pulses += int'(mult_start);
    repeat (3) begin @(negedge clk); pulses += int'(mult_start); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL basic_start_pulses act=%0d exp=1", pulses); end
    pulse_done();
    checks++; if (state_o !== 3'd4 || result_valid !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL basic_result act=st%0d/rv%0b/busy%0b/err%0b exp=4/1/0/0", state_o, result_valid, busy, error); end
    checks++; if (operand_a !== 8'h0C || operand_b !== 8'hFB) begin errors++; $display("FAIL basic_hold act=%h/%h exp=0c/fb", operand_a, operand_b); end
    press(K_ENTER);
    checks++; if (state_o !== 3'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL basic_exit act=st%0d/rv%0b exp=0/0", state_o, result_valid); end
  endtask

  task automatic test_saturate();
    press(4'd9); press(4'd9); press(4'd9);
    checks++; if (entry_mag !== 8'd127) begin errors++; $display("FAIL sat_mag act=%0d exp=127", entry_mag); end
    press(K_ENTER);
    checks++; if (operand_a !== 8'h7F) begin errors++; $display("FAIL sat_op_a act=%h exp=7f", operand_a); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (entry_mag !== 8'd123) begin errors++; $display("FAIL digit_limit_mag act=%0d exp=123", entry_mag); end
    press(K_ENTER);
    checks++; if (operand_b !== 8'd123 || state_o !== 3'd2) begin errors++; $display("FAIL digit_limit_op_b act=%0d/st%0d exp=123/2", operand_b, state_o); end
    @(negedge clk);
  endtask

  task automatic test_done_with_key();
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL dk_in_wait act=%0d exp=3", state_o); end
    @(negedge clk);
    mult_done = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk);
    mult_done = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    $display("done+key -> state=%0d rv=%0b mag=%0d", state_o, result_valid, entry_mag);
    checks++; if (state_o !== 3'd4 || result_valid !== 1'b1) begin errors++; $display("FAIL dk_result act=st%0d/rv%0b exp=4/1", state_o, result_valid); end
    checks++; if (entry_mag !== 8'd0) begin errors++; $display("FAIL dk_key_discard act=%0d exp=0", entry_mag); end
    press(4'd7);
    checks++; if (state_o !== 3'd0 || entry_mag !== 8'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL dk_consume act=st%0d/mag%0d/rv%0b exp=0/0/0", state_o, entry_mag, result_valid); end
    checks++; if (operand_b !== 8'd123) begin errors++; $display("FAIL dk_op_b_held act=%0d exp=123", operand_b); end
  endtask

  task automatic test_clear();
    press(4'd7); press(K_NEG); press(K_CLR);
    checks++; if (entry_neg !== 1'b0 || entry_mag !== 8'd0 || operand_a !== 8'd0 || operand_b !== 8'd0) begin errors++; $display("FAIL clr_zero act=neg%0b/mag%0d/a%h/b%h exp=0/0/00/00", entry_neg, entry_mag, operand_a, operand_b); end
    press(4'd3); press(K_ENTER);
    checks++; if (operand_a !== 8'd3 || entry_neg !== 1'b0 || state_o !== 3'd1) begin errors++; $display("FAIL clr_op_a act=%0d/neg%0b/st%0d exp=3/0/1", operand_a, entry_neg, state_o); end
    press(4'hD);
    checks++; if (entry_mag !== 8'd0 || state_o !== 3'd1) begin errors++; $display("FAIL ignored_code act=mag%0d/st%0d exp=0/1", entry_mag, state_o); end
    pulse_done();
    checks++; if (state_o !== 3'd1 || result_valid !== 1'b0) begin errors++; $display("FAIL done_in_b act=st%0d/rv%0b exp=1/0", state_o, result_valid); end
    press(K_CLR);
    checks++; if (state_o !== 3'd0 || operand_a !== 8'd0) begin errors++; $display("FAIL clr_from_b act=st%0d/a%h exp=0/00", state_o, operand_a); end
    pulse_done();
    checks++; if (state_o !== 3'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL done_in_a act=st%0d/rv%0b exp=0/0", state_o, result_valid); end
    press(K_NEG); press(K_ENTER);
    checks++; if (operand_a !== 8'd0 || state_o !== 3'd1 || entry_neg !== 1'b0) begin errors++; $display("FAIL empty_enter act=a%h/st%0d/neg%0b exp=00/1/0", operand_a, state_o, entry_neg); end
    press(K_CLR);
  endtask

  task automatic test_wait_limit();
    press(4'd2); press(K_ENTER); press(K_NEG); press(4'd3); press(K_ENTER);
    @(negedge clk);
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL wl_enter_wait act=%0d exp=3", state_o); end
`ifdef BOOTH_CTRL_TIMEOUT_EN
    repeat (15) @(negedge clk);
    checks++; if (state_o !== 3'd3 || error !== 1'b0) begin errors++; $display("FAIL to_before act=st%0d/err%0b exp=3/0", state_o, error); end
    @(negedge clk);
    $display("watchdog -> state=%0d err=%0b rv=%0b", state_o, error, result_valid);
    checks++; if (state_o !== 3'd4 || error !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL to_expire act=st%0d/err%0b/rv%0b exp=4/1/0", state_o, error, result_valid); end
    press(4'd1);
    checks++; if (state_o !== 3'd0 || error !== 1'b0) begin errors++; $display("FAIL to_exit act=st%0d/err%0b exp=0/0", state_o, error); end
`else
    press(4'd5);
    checks++; if (entry_mag !== 8'd0 || state_o !== 3'd3) begin errors++; $display("FAIL wait_key_discard act=mag%0d/st%0d exp=0/3", entry_mag, state_o); end
    repeat (1000) @(negedge clk);
    $display("after 1000 cycles -> state=%0d busy=%0b err=%0b", state_o, busy, error);
    checks++; if (state_o !== 3'd3 || busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL wait_forever act=st%0d/busy%0b/err%0b exp=3/1/0", state_o, busy, error); end
    pulse_done();
    checks++; if (state_o !== 3'd4 || result_valid !== 1'b1 || operand_a !== 8'd2 || operand_b !== 8'hFD) begin errors++; $display("FAIL wait_done act=st%0d/rv%0b/a%h/b%h exp=4/1/02/fd", state_o, result_valid, operand_a, operand_b); end
    press(4'd1);
`endif
  endtask

  task automatic test_reset_mid_wait();
    press(4'd4); press(K_ENTER); press(4'd2); press(K_ENTER);
    @(negedge clk);
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL rmw_in_wait act=%0d exp=3", state_o); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("async reset -> state=%0d a=%h b=%h busy=%0b", state_o, operand_a, operand_b, busy);
    checks++; if ({operand_a, operand_b, mult_start, entry_mag, entry_neg, state_o, busy, result_valid, error} !== 32'd0) begin errors++; $display("FAIL rmw_async act=%h exp=0", {operand_a, operand_b, mult_start, entry_mag, entry_neg, state_o, busy, result_valid, error}); end
    @(negedge clk);
    rst = 1'b0;
    pulse_done();
    checks++; if ({operand_a, operand_b, mult_start, entry_mag, entry_neg, state_o, busy, result_valid, error} !== 32'd0) begin errors++; $display("FAIL rmw_done_ignored act=%h exp=0", {operand_a, operand_b, mult_start, entry_mag, entry_neg, state_o, busy, result_valid, error}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_done_with_key();
    test_clear();
    test_wait_limit();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_entry_ctrl.md
# booth_entry_ctrl

Sequencer for the input subsystem of the Booth multiplier. It consumes single-cycle key pulses from the input subsystem's press-to-pulse converters, then:
- assembles two signed decimal operands digit by digit,
- launches the Booth datapath with a one-cycle start strobe,
- waits for completion,
- holds operands and status for the display subsystem until the next key.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (two's complement)
- MAX_DIGITS, 3, maximum decimal digits accepted per operand
- TIMEOUT_CYCLES, 64, watchdog limit in S_WAIT (used only with BOOTH_CTRL_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle pulse, one key event
- key_code  in  4  0–9 digit; 4'hA ENTER; 4'hB NEG (toggle sign); 4'hC CLEAR; 4'hD–4'hF ignored
- mult_done  in  1  Booth datapath completion pulse
- operand_a  out  WIDTH  signed multiplicand
- operand_b  out  WIDTH  signed multiplier
- mult_start  out  1  one-cycle launch strobe
- entry_mag  out  WIDTH  magnitude currently being typed (display)
- entry_neg  out  1  sign of the entry being typed
- state_o  out  3  encoded state: S_A=0, S_B=1, S_RUN=2, S_WAIT=3, S_RESULT=4
- busy  out  1  high in S_RUN and S_WAIT
- result_valid  out  1  high in S_RESULT when completion came from mult_done
- error  out  1  high in S_RESULT after a watchdog expiry

## Operation
- Reset values: state S_A; all outputs 0.
- S_A / S_B accept keys.
  - Digit d, when fewer than MAX_DIGITS digits are entered: entry_mag ← min(entry_mag*10+d, 2^(WIDTH-1)-1). Compute in WIDTH+4 bits, then clamp. Digits beyond MAX_DIGITS are ignored.
  - NEG toggles entry_neg.
  - CLEAR zeroes entry_mag, entry_neg, the digit count, operand_a and operand_b, and moves to S_A.
  - ENTER latches the signed value (entry_neg ? -entry_mag : entry_mag) into operand_a (S_A→S_B) or operand_b (S_B→S_RUN), then clears the entry. ENTER with zero digits latches 0.
- S_RUN: mult_start=1 for exactly this one cycle, then unconditionally S_WAIT.
- S_WAIT: mult_done → S_RESULT with result_valid=1. Keys are discarded.
- S_RESULT: operands held. Any key_valid → S_A, clearing the entry state and result_valid/error. That first key is consumed and is not interpreted as a digit.
- mult_done is ignored in every state except S_WAIT.
- key_valid and mult_done in the same S_WAIT cycle: mult_done wins and the key is discarded.
- operand_a and operand_b are stable from S_RUN until CLEAR or the next ENTER.

## Timing
- Moore outputs, all registered.
- Key sampled at edge k takes effect after edge k.
- ENTER of operand B at edge k: mult_start high in cycle k..k+1. operand_b is valid in that same cycle.
- mult_done at edge m: result_valid high from edge m onward.
- rst asserted in any state, including mid-S_WAIT, clears everything immediately, without waiting for a clock edge. A later mult_done is ignored.

## Configuration
- BOOTH_CTRL_TIMEOUT_EN defined:
  - A counter runs only in S_WAIT and starts from 0 on entry to S_WAIT.
  - If mult_done has not arrived when the counter reaches TIMEOUT_CYCLES, the block moves to S_RESULT with error=1 and result_valid=0.
  - mult_done arriving in the expiry cycle wins.
- BOOTH_CTRL_TIMEOUT_EN undefined: no counter; S_WAIT waits indefinitely; error is tied to 0.

## Test plan
- Keys 1,2,ENTER,NEG,5,ENTER (WIDTH=8) → operand_a=8'h0C, operand_b=8'hFB. mult_start is high for exactly 1 cycle after the second ENTER, then state_o=3.
- Keys 9,9,9,ENTER → operand_a=8'h7F (saturated). Keys 1,2,3,4,ENTER → operand_b=123 (fourth digit ignored).
- In S_WAIT, pulse mult_done together with a key → state_o=4, result_valid=1. The key has no effect; the next key returns the block to S_A with entry_mag=0.
- Keys 7,NEG,CLEAR,3,ENTER → operand_a=3, entry_neg=0. mult_done pulsed in S_A or S_B → no state change.
- BOOTH_CTRL_TIMEOUT_EN with TIMEOUT_CYCLES=16, mult_done never pulsed → error=1, result_valid=0 after 16 cycles in S_WAIT. Without the macro → still in S_WAIT after 1000 cycles.
- rst pulsed mid-S_WAIT, then mult_done → all outputs 0, state_o=0.
